// File: rtl/instr_issue_sequencer_pkg.sv
// Shared definitions for the instruction issue sequencer: FSM state encoding and
// MIPS opcode constants plus an I-type word builder used by benches.
package instr_issue_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRE_RST = 2'd1,
    S_ISSUE   = 2'd2,
    S_WAIT    = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  function automatic logic [31:0] mk_itype(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_issue_sequencer_sync_fifo.sv
// Synchronous FIFO with flush; head word is visible on rdata_o while count_o > 0.
module instr_issue_sequencer_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage array carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_issue_sequencer.sv
// Issues buffered instruction words to the core one at a time: optional core reset
// pulse, one-cycle Newinstr strobe, then wait for cpu_done or a timeout.
module instr_issue_sequencer
  import instr_issue_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned RESET_BETWEEN = 1,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_instr,
  output logic                       in_ready,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           Instrword,
  output logic                       Newinstr,
  output logic                       cpu_reset,
  input  logic                       cpu_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [CNT_W-1:0]           issued_count,
  output logic                       timeout_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             newinstr_q, newinstr_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             err_q, err_d;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;

  assign in_ready = (fifo_count < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  instr_issue_sequencer_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .wdata_i(in_instr),
    .rdata_o(head),
    .count_o(fifo_count)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      newinstr_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
      timer_q     <= '0;
      issued_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      newinstr_q  <= newinstr_d;
      cpu_reset_q <= cpu_reset_d;
      timer_q     <= timer_d;
      issued_q    <= issued_d;
      err_q       <= err_d;
    end
  end

  // Strobes are registered decodes of the state, so each lands one cycle after entry.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    timer_d     = timer_q;
    issued_d    = issued_q;
    err_d       = err_q;
    pop         = 1'b0;
    newinstr_d  = (state_q == S_ISSUE);
    cpu_reset_d = (state_q == S_PRE_RST);

    if (err_clr) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A flush cycle must not pop, or the popped word would survive the flush.
        if (enable && (fifo_count != '0) && !flush) begin
          pop     = 1'b1;
          instr_d = head;
          state_d = (RESET_BETWEEN != 0) ? S_PRE_RST : S_ISSUE;
        end
      end
      S_PRE_RST: state_d = S_ISSUE;
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cpu_done) begin
          issued_d = issued_q + CNT_W'(1);
          state_d  = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Instrword    = instr_q;
  assign Newinstr     = newinstr_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = (state_q != S_IDLE);
  assign issued_count = issued_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed bench: instance A uses RESET_BETWEEN=1, instance B uses RESET_BETWEEN=0.
module tb_instr_issue_sequencer;
  import instr_issue_sequencer_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned CN = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_en, a_flush, a_clr, a_ni, a_cr, a_done, a_busy, a_err;
  logic [W-1:0]  a_instr, a_word;
  logic [CW-1:0] a_cnt;
  logic [CN-1:0] a_issued;
  logic          a_auto, a_man, a_ni_d;

  logic          b_valid, b_ready, b_en, b_flush, b_clr, b_ni, b_cr, b_done, b_busy, b_err;
  logic [W-1:0]  b_instr, b_word;
  logic [CW-1:0] b_cnt;
  logic [CN-1:0] b_issued;
  logic          b_auto;

  instr_issue_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_BETWEEN(1), .TIMEOUT(16), .CNT_W(CN)) u_dut_a (
    .Clock(clk), .Reset(rst), .in_valid(a_valid), .in_instr(a_instr), .in_ready(a_ready),
    .enable(a_en), .flush(a_flush), .err_clr(a_clr), .Instrword(a_word), .Newinstr(a_ni),
    .cpu_reset(a_cr), .cpu_done(a_done), .busy(a_busy), .fifo_count(a_cnt),
    .issued_count(a_issued), .timeout_err(a_err)
  );

  instr_issue_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_BETWEEN(0), .TIMEOUT(16), .CNT_W(CN)) u_dut_b (
    .Clock(clk), .Reset(rst), .in_valid(b_valid), .in_instr(b_instr), .in_ready(b_ready),
    .enable(b_en), .flush(b_flush), .err_clr(b_clr), .Instrword(b_word), .Newinstr(b_ni),
    .cpu_reset(b_cr), .cpu_done(b_done), .busy(b_busy), .fifo_count(b_cnt),
    .issued_count(b_issued), .timeout_err(b_err)
  );

  // Core model: A answers one cycle after Newinstr, B answers in the Newinstr cycle.
  always @(posedge clk) a_ni_d <= a_ni;
  assign a_done = a_man | (a_auto & a_ni_d);
  assign b_done = b_auto & b_ni;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] aw[$];
  int           acyc[$];
  int           arst[$];
  logic [W-1:0] bw[$];
  int           bcyc[$];
  logic         b_rst_seen = 1'b0;

  always @(negedge clk) begin
    if (a_ni) begin aw.push_back(a_word); acyc.push_back(cyc); end
    if (a_cr) arst.push_back(cyc);
    if (b_ni) begin bw.push_back(b_word); bcyc.push_back(cyc); end
    if (b_cr) b_rst_seen = 1'b1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle_a(input int limit);
    int k = 0;
    while ((a_busy || a_cnt != '0) && k < limit) begin step(); k++; end
    chk("a_idle_bound", 64'(k < limit), 64'd1);
  endtask

  function automatic logic [31:0] lw(input int rt, input int imm);
    return mk_itype(OP_LW, 5'd0, 5'(rt), 16'(imm));
  endfunction

  logic [W-1:0] exp_w[$];
  int n0;

  initial begin
    a_valid = 0; a_instr = '0; a_en = 0; a_flush = 0; a_clr = 0; a_auto = 0; a_man = 0;
    b_valid = 0; b_instr = '0; b_en = 0; b_flush = 0; b_clr = 0; b_auto = 0;

    step(2);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_word", 64'(a_word), 64'd0);
    rst = 0;
    step();
    chk("rel_ready", 64'(a_ready), 64'd1);

    // RESET_BETWEEN=0 stream, immediate done: one issue every 3 cycles
    b_en = 1; b_auto = 1;
    exp_w.delete();
    for (int i = 0; i < 6; i++) begin
      b_valid = 1; b_instr = mk_itype(OP_RTYPE, 5'(i), 5'(i + 1), 16'h0020);
      exp_w.push_back(b_instr);
      step();
      if (i == 0) n0 = cyc;
    end
    b_valid = 0;
    step(30);
    chk("b_n_issued", 64'(bw.size()), 64'd6);
    chk("b_first_lat", 64'(bcyc.size() > 0 ? bcyc[0] - n0 : -1), 64'd2);
    for (int i = 0; i < 6 && i < bw.size(); i++) begin
      chk($sformatf("b_word%0d", i), 64'(bw[i]), 64'(exp_w[i]));
      if (i > 0) chk($sformatf("b_space%0d", i), 64'(bcyc[i] - bcyc[i-1]), 64'd3);
    end
    chk("b_no_cpu_reset", 64'(b_rst_seen), 64'd0);
    chk("b_issued_cnt", 64'(b_issued), 64'd6);

    // Three LWs with reset pulse before each issue
    a_en = 1; a_auto = 1;
    exp_w.delete();
    exp_w.push_back(32'h8C010000); exp_w.push_back(32'h8C020001); exp_w.push_back(32'h8C030002);
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_instr = lw(i + 1, i);
      step();
      if (i == 0) n0 = cyc;
    end
    a_valid = 0;
    wait_idle_a(100);
    step(2);
    chk("lw_n_issued", 64'(aw.size()), 64'd3);
    chk("lw_n_resets", 64'(arst.size()), 64'd3);
    chk("lw_first_lat", 64'(acyc.size() > 0 ? acyc[0] - n0 : -1), 64'd3);
    for (int i = 0; i < 3 && i < aw.size(); i++) begin
      chk($sformatf("lw_word%0d", i), 64'(aw[i]), 64'(exp_w[i]));
      if (i < arst.size()) chk($sformatf("lw_rst_lead%0d", i), 64'(acyc[i] - arst[i]), 64'd1);
      if (i > 0) chk($sformatf("lw_space%0d", i), 64'(acyc[i] - acyc[i-1]), 64'd5);
    end
    chk("lw_issued_cnt", 64'(a_issued), 64'd3);

    // Fill with enable low, 9th push refused, then drain in order
    aw.delete(); acyc.delete(); arst.delete(); exp_w.delete();
    a_en = 0;
    for (int i = 0; i < 9; i++) begin
      a_valid = 1; a_instr = lw(i + 4, 16 * i);
      if (i < 8) exp_w.push_back(a_instr);
      step();
    end
    a_valid = 0;
    chk("full_cnt", 64'(a_cnt), 64'd8);
    chk("full_ready", 64'(a_ready), 64'd0);
    chk("full_busy", 64'(a_busy), 64'd0);
    a_en = 1;
    wait_idle_a(200);
    step(2);
    chk("drain_n", 64'(aw.size()), 64'd8);
    for (int i = 0; i < 8 && i < aw.size(); i++)
      chk($sformatf("drain_word%0d", i), 64'(aw[i]), 64'(exp_w[i]));
    chk("drain_issued_cnt", 64'(a_issued), 64'd11);

    // Timeout: no cpu_done, back to IDLE 16 cycles after Newinstr
    rst = 1; step(); rst = 0; step();
    chk("to_issued_rst", 64'(a_issued), 64'd0);
    a_auto = 0;
    a_valid = 1; a_instr = mk_itype(OP_SW, 5'd2, 5'd3, 16'h0004);
    step();
    n0 = cyc;
    a_valid = 0;
    step(3);
    chk("to_newinstr", 64'(a_ni), 64'd1);
    step(15);
    chk("to_busy_last", 64'(a_busy), 64'd1);
    chk("to_err_early", 64'(a_err), 64'd0);
    step();
    chk("to_idle", 64'(a_busy), 64'd0);
    chk("to_err", 64'(a_err), 64'd1);
    chk("to_issued", 64'(a_issued), 64'd0);
    a_clr = 1; step(); a_clr = 0;
    chk("to_err_clr", 64'(a_err), 64'd0);

    // Flush during WAIT: in-flight completes, nothing else issues
    aw.delete(); acyc.delete(); arst.delete(); exp_w.delete();
    a_en = 0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1; a_instr = lw(i + 10, 100 + i);
      exp_w.push_back(a_instr);
      step();
    end
    a_valid = 0;
    a_en = 1;
    step(3);
    chk("fl_newinstr", 64'(a_ni), 64'd1);
    chk("fl_cnt_before", 64'(a_cnt), 64'd5);
    a_flush = 1; step(); a_flush = 0;
    chk("fl_cnt_after", 64'(a_cnt), 64'd0);
    chk("fl_busy_wait", 64'(a_busy), 64'd1);
    a_man = 1; step(); a_man = 0;
    chk("fl_done_idle", 64'(a_busy), 64'd0);
    chk("fl_issued", 64'(a_issued), 64'd1);
    step(10);
    chk("fl_n_issued", 64'(aw.size()), 64'd1);
    if (aw.size() > 0) chk("fl_word", 64'(aw[0]), 64'(exp_w[0]));

    // Async reset in the middle of WAIT
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_instr = lw(20 + i, 7);
      step();
    end
    a_valid = 0;
    step();
    chk("mr_busy_pre", 64'(a_busy), 64'd1);
    chk("mr_ni_pre", 64'(a_ni), 64'd1);
    chk("mr_cnt_pre", 64'(a_cnt), 64'd2);
    rst = 1;
    #1;
    chk("mr_ni", 64'(a_ni), 64'd0);
    chk("mr_cr", 64'(a_cr), 64'd0);
    chk("mr_busy", 64'(a_busy), 64'd0);
    chk("mr_word", 64'(a_word), 64'd0);
    chk("mr_cnt", 64'(a_cnt), 64'd0);
    chk("mr_issued", 64'(a_issued), 64'd0);
    chk("mr_err", 64'(a_err), 64'd0);
    step();
    rst = 0;
    step();
    chk("mr_ready", 64'(a_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
